// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo front end: instruction field slices,
// the raw 16-bit instruction word and the fetch-queue entry payload.
package tomasulo_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 32;

  // Instruction field slices within instr_t
  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;
  localparam int unsigned RS1_HI = 11;
  localparam int unsigned RS1_LO = 8;
  localparam int unsigned RS2_HI = 7;
  localparam int unsigned RS2_LO = 4;
  localparam int unsigned RD_HI  = 3;
  localparam int unsigned RD_LO  = 0;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    instr_t            instr;
    logic [ADDR_W-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// DEPTH-entry storage for the fetch queue.
// Ports:
//   clk1, rst        - clock, synchronous active-high reset
//   clear            - drop all entries (overrides push/pop)
//   push, push_data  - write an entry at the tail
//   pop              - retire the head entry
//   count            - current occupancy (registered)
//   count_nxt_c      - occupancy after this edge
//   head_nxt_c       - head entry after this edge (same-edge write forwarded)
module fq_fifo
  import tomasulo_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk1,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  fq_entry_t                  push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_nxt_c,
  output fq_entry_t                  head_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fq_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_c, pop_c;

  // Pointer and occupancy update; clear wins over everything
  always_comb begin
    push_c  = push && !clear;
    pop_c   = pop && !clear;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_c) tail_d = tail_q + PTR_W'(1);
      if (pop_c)  head_d = head_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Head after the edge; a write landing on the new head slot is forwarded
  always_comb begin
    head_nxt_c = mem_q[head_d];
    if (push_c && (tail_q == head_d)) head_nxt_c = push_data;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count
  always_ff @(posedge clk1) begin
    if (push_c) mem_q[tail_q] <= push_data;
  end

  assign count       = count_q;
  assign count_nxt_c = count_d;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, requests words from a 1-cycle instruction
// memory, queues the returned words and offers the decoded head to issue.
// Ports:
//   clk1, rst                 - clock, synchronous active-high reset
//   pc, imem_data             - fetch address out, read data back one cycle later
//   redirect, redirect_pc     - flush queue and restart fetch at redirect_pc
//   iss_valid/iss_ready       - issue handshake; iss_* fields are registered
//   done                      - program exhausted, queue empty, nothing in flight
//   stall_cnt, fetch_cnt      - perf counters, present only with FETCHQ_PERF_CNT_EN
module fetch_queue
  import tomasulo_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PROG_LEN = 6
) (
  input  logic        clk1,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [3:0]  iss_opcode,
  output logic [3:0]  iss_rs1,
  output logic [3:0]  iss_rs2,
  output logic [3:0]  iss_rd,
  output logic [31:0] iss_pc,
`ifdef FETCHQ_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] fetch_cnt,
`endif
  output logic        done
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic             iss_valid_q, iss_valid_d;
  fq_entry_t        iss_entry_q, iss_entry_d;
  logic             done_q, done_d;

  logic             fire_c, capture_c, pop_c, clear_c;
  logic [CNT_W-1:0] count, count_nxt;
  fq_entry_t        head_nxt, push_data;
  logic             unused_imem_hi;

  assign unused_imem_hi = ^imem_data[31:16];

  // Request gating; in-flight slot is reserved so a capture never overflows
  always_comb begin
    clear_c   = rst || redirect;
    fire_c    = !rst && !redirect && (pc_q < 32'(PROG_LEN)) &&
                ((SUM_W'(count) + SUM_W'(inflight_q)) < SUM_W'(DEPTH));
    capture_c = inflight_q && !clear_c;
    pop_c     = iss_valid_q && iss_ready && !clear_c;
    push_data = '{instr: instr_t'(imem_data[15:0]), pc: inflight_pc_q};
  end

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk1        (clk1),
    .rst         (rst),
    .clear       (clear_c),
    .push        (capture_c),
    .push_data   (push_data),
    .pop         (pop_c),
    .count       (count),
    .count_nxt_c (count_nxt),
    .head_nxt_c  (head_nxt)
  );

  // Next state for PC, in-flight tracking and registered issue outputs
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = fire_c;
    inflight_pc_d = inflight_pc_q;
    if (redirect)    pc_d = redirect_pc;
    else if (fire_c) pc_d = pc_q + 32'd1;
    if (fire_c) inflight_pc_d = pc_q;
    iss_valid_d = (count_nxt != '0);
    // Fields hold their last value while the queue is empty
    iss_entry_d = iss_valid_d ? head_nxt : iss_entry_q;
    done_d      = (pc_d >= 32'(PROG_LEN)) && (count_nxt == '0) && !inflight_d;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      iss_valid_q   <= 1'b0;
      iss_entry_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      iss_valid_q   <= iss_valid_d;
      iss_entry_q   <= iss_entry_d;
      done_q        <= done_d;
    end
  end

  assign pc         = pc_q;
  assign iss_valid  = iss_valid_q;
  assign iss_opcode = iss_entry_q.instr[OPC_HI:OPC_LO];
  assign iss_rs1    = iss_entry_q.instr[RS1_HI:RS1_LO];
  assign iss_rs2    = iss_entry_q.instr[RS2_HI:RS2_LO];
  assign iss_rd     = iss_entry_q.instr[RD_HI:RD_LO];
  assign iss_pc     = iss_entry_q.pc;
  assign done       = done_q;

`ifdef FETCHQ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  // Saturating perf counters; cleared only by reset
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    if (iss_valid_q && !iss_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (fire_c && (fetch_cnt_q != '1))                    fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fetch_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a scoreboard of expected issues
// (pc + instruction word) is compared against every accepted handshake.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned PROG_LEN = 6;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic [31:0] imem_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        iss_valid;
  logic        iss_ready = 1'b0;
  logic [3:0]  iss_opcode, iss_rs1, iss_rs2, iss_rd;
  logic [31:0] iss_pc;
  logic        done;
`ifdef FETCHQ_PERF_CNT_EN
  logic [31:0] stall_cnt, fetch_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [47:0] sb [$];
  logic [15:0] prog [8];

  fetch_queue #(.DEPTH(DEPTH), .PROG_LEN(PROG_LEN)) dut (
    .clk1        (clk1),
    .rst         (rst),
    .pc          (pc),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_opcode  (iss_opcode),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .iss_rd      (iss_rd),
    .iss_pc      (iss_pc),
`ifdef FETCHQ_PERF_CNT_EN
    .stall_cnt   (stall_cnt),
    .fetch_cnt   (fetch_cnt),
`endif
    .done        (done)
  );

  always #5 clk1 = ~clk1;

  // Registered instruction memory; upper half carries junk that must be ignored
  always @(posedge clk1) begin
    if (pc < 32'(PROG_LEN)) imem_data <= {16'hC3C3, prog[pc[2:0]]};
    else                    imem_data <= {16'hC3C3, 16'h0000};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: compare every accepted issue against the oldest expectation
  always @(negedge clk1) begin
    if (iss_valid && iss_ready && !redirect && !rst) begin
      check("issue_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0)
        check("issue_entry", 64'({iss_pc, iss_opcode, iss_rs1, iss_rs2, iss_rd}),
              64'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic push_exp(input int unsigned first, input int unsigned last);
    for (int unsigned i = first; i <= last; i++) sb.push_back({32'(i), prog[i]});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},        64'(pc), 64'd0);
    check({tag, "_valid"},     64'(iss_valid), 64'd0);
    check({tag, "_fields"},    64'({iss_opcode, iss_rs1, iss_rs2, iss_rd}), 64'd0);
    check({tag, "_iss_pc"},    64'(iss_pc), 64'd0);
    check({tag, "_done"},      64'(done), 64'd0);
  endtask

  // Leaves the bench in the first cycle with rst low
  task automatic do_reset(input string tag);
    rst = 1'b1;
    redirect = 1'b0;
    iss_ready = 1'b0;
    sb.delete();
    tick();
    tick();
    check_reset_outputs(tag);
    rst = 1'b0;
  endtask

  task automatic run_until_done(input string tag);
    int n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    prog[0] = 16'h2123; prog[1] = 16'h0345; prog[2] = 16'h0267;
    prog[3] = 16'h089A; prog[4] = 16'h27AB; prog[5] = 16'h0000;
    prog[6] = 16'h0000; prog[7] = 16'h0000;

    // Test 1: streaming with iss_ready held high
    do_reset("t1_rst");
    push_exp(0, 5);
    iss_ready = 1'b1;
    tick();
    check("t1_valid_early", 64'(iss_valid), 64'd0);
    tick();
    check("t1_valid_first", 64'(iss_valid), 64'd1);
    check("t1_first_fields", 64'({iss_opcode, iss_rs1, iss_rs2, iss_rd}), 64'h2123);
    for (int i = 1; i < 6; i++) begin
      tick();
      check("t1_valid_stream", 64'(iss_valid), 64'd1);
    end
    tick();
    check("t1_done", 64'(done), 64'd1);
    check("t1_valid_end", 64'(iss_valid), 64'd0);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Test 2: back-pressure fills the queue, then drains in order
    do_reset("t2_rst");
    push_exp(0, 5);
    tick();
    tick();
    check("t2_valid", 64'(iss_valid), 64'd1);
    for (int i = 0; i < 10; i++) tick();
    check("t2_pc_stall", 64'(pc), 64'd4);
    check("t2_head_pc", 64'(iss_pc), 64'd0);
    iss_ready = 1'b1;
    run_until_done("t2");
`ifdef FETCHQ_PERF_CNT_EN
    check("t2_stall_cnt", 64'(stall_cnt), 64'd10);
    check("t2_fetch_cnt", 64'(fetch_cnt), 64'd6);
`endif

    // Test 3: redirect to 3 with two entries queued and one in flight
    do_reset("t3_rst");
    push_exp(3, 5);
    tick();
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'd3;
    tick();
    redirect = 1'b0;
    check("t3_valid_flushed", 64'(iss_valid), 64'd0);
    check("t3_pc_redirect", 64'(pc), 64'd3);
    iss_ready = 1'b1;
    run_until_done("t3");

    // Test 4: redirect beyond program end together with iss_ready
    do_reset("t4_rst");
    tick();
    tick();
    check("t4_valid", 64'(iss_valid), 64'd1);
    redirect = 1'b1;
    redirect_pc = 32'(PROG_LEN);
    iss_ready = 1'b1;
    tick();
    redirect = 1'b0;
    check("t4_valid_dropped", 64'(iss_valid), 64'd0);
    check("t4_pc_halt", 64'(pc), 64'(PROG_LEN));
    tick();
    check("t4_done", 64'(done), 64'd1);
    check("t4_valid_stay", 64'(iss_valid), 64'd0);
    check("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Test 5: reset asserted mid-stream, then a clean restart from pc 0
    do_reset("t5_rst");
    push_exp(0, 2);
    iss_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("t5_mid_rst");
    check("t5_sb_drained", 64'(sb.size()), 64'd0);
    rst = 1'b0;
    push_exp(0, 5);
    run_until_done("t5");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Front-end fetch stage of the Tomasulo core. Owns the program counter, drives it into the registered instruction memory, and captures the returned words into a small FIFO. Each head word is split into opcode/register fields and offered to the issue stage over a valid/ready handshake. Supports redirect (flush) and stops at end of program.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- PROG_LEN, 6: number of instruction words. Fetching stops once PC reaches PROG_LEN.

Ports:
- clk1, input, 1: the single clock. Sampled on its rising edge.
- rst, input, 1: synchronous reset, active high.
- pc, output, 32: fetch address to instruction memory.
- imem_data, input, 32: memory read data, valid exactly 1 cycle after `pc` is presented. Bits [15:0] are used; [31:16] are ignored.
- redirect, input, 1: flush and restart fetching at `redirect_pc`.
- redirect_pc, input, 32: new fetch address.
- iss_valid, output, 1: queue head is valid.
- iss_ready, input, 1: issue stage accepts the head this cycle.
- iss_opcode, output, 4: head bits [15:12].
- iss_rs1, output, 4: head bits [11:8].
- iss_rs2, output, 4: head bits [7:4].
- iss_rd, output, 4: head bits [3:0].
- iss_pc, output, 32: address of the head instruction.
- done, output, 1: PC has reached PROG_LEN, the queue is empty and nothing is in flight.

## Operation
- **Fetch request** (`fire`): issued in a cycle when all of the following hold:
  - not `rst`;
  - not `redirect`;
  - pc < PROG_LEN;
  - count + inflight < DEPTH.
- On `fire`, pc increments by 1 on the next edge, and a pending-response flag (`inflight`) records the request's address for the following cycle.
- **Capture**: the cycle after a `fire`, {imem_data[15:0], request pc} is written at the tail pointer.
- **Dequeue**: occurs when iss_valid && iss_ready. The head pointer advances.
- **Simultaneous capture and dequeue**: count is unchanged, and both pointers advance.
- **Pointers**: log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits.
- **Full queue**: `fire` is suppressed, so a capture never overflows.
- **Empty queue**: iss_valid=0. Field outputs hold their last value and are don't-care.
- **Redirect**:
  - On the next edge: pc <= redirect_pc; count, head and tail are cleared.
  - Any response from a fetch issued in the redirect cycle or the cycle before is discarded.
  - Redirect overrides a simultaneous dequeue and capture.
  - If redirect_pc >= PROG_LEN, fetching stays halted and done asserts once inflight clears.
- **Reset values**: pc=0, count=0, pointers=0, inflight=0, iss_valid=0, all field outputs 0, iss_pc=0, done=0.
- **Reset mid-operation**: behaves exactly like redirect to 0, and also clears counters.

## Timing
- **Steady state**: one instruction per cycle when iss_ready is held high and the queue is not full.
- **Latency**: pc presented in cycle N; word captured at the end of N+1; iss_valid visible in N+2 at the earliest.
- **After reset or redirect**: first iss_valid appears 2 cycles after the deassertion edge.
- **Output registering**: iss_* are driven from the registered head entry. No combinational path from iss_ready to iss_valid.
- **Handshake**: iss_ready may depend on iss_valid. iss_valid must not depend on iss_ready.

## Configuration
- Macro: `FETCHQ_PERF_CNT_EN`.
- **Defined**: adds output ports `stall_cnt[31:0]` and `fetch_cnt[31:0]`.
  - `stall_cnt` counts cycles with iss_valid=1 and iss_ready=0.
  - `fetch_cnt` counts `fire` cycles.
  - Both reset to 0 on `rst` and saturate at all-ones. Redirect does not clear them.
- **Undefined**: neither port nor counter exists. Behaviour is otherwise identical.

## Structure
- **Shared package `tomasulo_pkg`** holds:
  - field slice constants OPC_HI/LO, RS1_HI/LO, RS2_HI/LO, RD_HI/LO;
  - typedef `instr_t` (16 bits);
  - typedef `fq_entry_t` = {instr_t, 32-bit pc}.
- **Sub-module `fq_fifo`**: the DEPTH-entry storage with pointers, count, push, pop and clear. fetch_queue holds the PC, the inflight flag, the decode and the counters.

## Test plan
- **Reset, iss_ready=1, program 0x2123, 0x0345, 0x0267, 0x089A, 0x27AB, 0x0000**:
  - iss_valid first rises 2 cycles after reset release;
  - six issues in consecutive cycles with iss_pc 0..5;
  - first issue has opcode=2, rs1=1, rs2=2, rd=3;
  - done=1 after the sixth.
- **iss_ready=0 for 10 cycles**: count settles at DEPTH=4 and pc stalls at 4. After releasing iss_ready, PCs 0..5 issue in order with no loss or duplication.
- **Redirect to 3 while 2 entries are queued and 1 is in flight**: no issue carries pc 0–2 afterwards; next issues are pc 3, 4, 5.
- **Redirect and iss_ready both high in the same cycle**: the head is dropped and the queue becomes empty next cycle.
- **rst asserted mid-stream at cycle 5**: all outputs return to reset values next edge, and fetch restarts at pc 0.
- **With `FETCHQ_PERF_CNT_EN`**: after test 2, stall_cnt=10 and fetch_cnt=6.
